// File: rtl/cache_pkg.sv
// Shared cache-controller definitions.
//
// Contents:
//   op_e       - request operation codes (read, write, evict, flush, upgrade)
//   id_e       - controller identifiers used for src/dest (L1I, L1D, L2, MEM)
//   req_t      - request record {src, dest, is_flush, operation, addr} at the
//                default widths; width-parameterised blocks build their own
//                layout with the same field order
//   offset_bits() - line offset width derived from the line size in bits
package cache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_ID_W   = 2;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_READ    = 3'd0,
    OP_WRITE   = 3'd1,
    OP_EVICT   = 3'd2,
    OP_FLUSH   = 3'd3,
    OP_UPGRADE = 3'd4
  } op_e;

  typedef enum logic [DEF_ID_W-1:0] {
    ID_L1I = 2'd0,
    ID_L1D = 2'd1,
    ID_L2  = 2'd2,
    ID_MEM = 2'd3
  } id_e;

  typedef struct packed {
    id_e                   src;
    id_e                   dest;
    logic                  is_flush;
    op_e                   operation;
    logic [DEF_ADDR_W-1:0] addr;
  } req_t;

  // Byte-offset bits within a cache line; cl_size is the line size in bits.
  function automatic int offset_bits(input int cl_size);
    return $clog2(cl_size / 8);
  endfunction

endpackage

// File: rtl/req_q_match.sv
// Line-address hazard comparator for req_q.
//
// Compares the line address (offset bits dropped) of every valid queue entry
// against a probe address and ORs the results.
//
// Ports:
//   entry_addr  [Q_LENGTH][ADDR_W]  stored address of each slot
//   entry_valid [Q_LENGTH]          slot holds a live request
//   match_addr  [ADDR_W]            probe address
//   match_hit                       some live slot is on the same line
module req_q_match
  import cache_pkg::*;
#(
  parameter int Q_LENGTH = 8,
  parameter int ADDR_W   = 32,
  parameter int CL_SIZE  = 128
) (
  input  logic [Q_LENGTH-1:0][ADDR_W-1:0] entry_addr,
  input  logic [Q_LENGTH-1:0]             entry_valid,
  input  logic [ADDR_W-1:0]               match_addr,
  output logic                            match_hit
);

  localparam int OFF = offset_bits(CL_SIZE);

  logic [Q_LENGTH-1:0] hit_vec;
  logic                unused_offset;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < Q_LENGTH; i++) begin
      hit_vec[i] = entry_valid[i] &&
                   (entry_addr[i][ADDR_W-1:OFF] == match_addr[ADDR_W-1:OFF]);
    end
  end

  // Byte-offset bits never take part in the line compare.
  always_comb begin
    unused_offset = ^match_addr[OFF-1:0];
    for (int i = 0; i < Q_LENGTH; i++) begin
      unused_offset = unused_offset ^ (^entry_addr[i][OFF-1:0]);
    end
  end

  assign match_hit = |hit_vec;

endmodule

// File: rtl/req_q.sv
// In-order request queue between cache controllers.
//
// Circular buffer of Q_LENGTH entries carrying {src, dest, is_flush,
// operation, addr}, with occupancy count, almost-full warning and a
// line-address match port for same-line hazard detection.
//
// Optional build macro REQ_Q_BYPASS_EN: when the queue is empty and alloc is
// high, the input request is presented at the head in the same cycle; if it
// is also dealloc'd that cycle it is consumed without being stored. Without
// the macro the head always has a 1-cycle latency.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   addr_in, operation_in,
//   is_flush, src, dest           request fields to push
//   alloc / dealloc               push / pop head
//   match_addr                    probe address for line hazard
//   full, almost_full, count      occupancy status (registered)
//   match_hit                     probe hits a live entry's line
//   addr_out, operation_out,
//   src_out, dest_out,
//   is_flush_out, valid           head entry
module req_q
  import cache_pkg::*;
#(
  parameter int Q_LENGTH  = 8,
  parameter int ADDR_W    = 32,
  parameter int OP_W      = 3,
  parameter int ID_W      = 2,
  parameter int CL_SIZE   = 128,
  parameter int AF_THRESH = Q_LENGTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr_in,
  input  logic [OP_W-1:0]           operation_in,
  input  logic                      is_flush,
  input  logic [ID_W-1:0]           src,
  input  logic [ID_W-1:0]           dest,
  input  logic                      alloc,
  input  logic                      dealloc,
  input  logic [ADDR_W-1:0]         match_addr,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(Q_LENGTH):0] count,
  output logic                      match_hit,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [OP_W-1:0]           operation_out,
  output logic [ID_W-1:0]           src_out,
  output logic [ID_W-1:0]           dest_out,
  output logic                      is_flush_out,
  output logic                      valid
);

  localparam int PTR_W = $clog2(Q_LENGTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(Q_LENGTH);
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);

  typedef struct packed {
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   dest;
    logic              is_flush;
    logic [OP_W-1:0]   operation;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t                          mem [Q_LENGTH];
  logic   [Q_LENGTH-1:0]           ent_vld;
  logic   [PTR_W-1:0]              wr_ptr;
  logic   [PTR_W-1:0]              rd_ptr;
  logic   [CNT_W-1:0]              cnt;

  entry_t                          in_req;
  entry_t                          head;
  logic                            empty;
  logic                            push_ok;
  logic                            pop_ok;
  logic [Q_LENGTH-1:0][ADDR_W-1:0] entry_addr;

  assign in_req = '{src: src, dest: dest, is_flush: is_flush,
                    operation: operation_in, addr: addr_in};

  assign empty       = (cnt == '0);
  assign full        = (cnt == Q_FULL);
  assign almost_full = (cnt >= AF_LVL);
  assign count       = cnt;

  // A pop on an empty queue is ignored; when full, a simultaneous pop frees
  // the slot the push lands in, so the push is still accepted.
`ifdef REQ_Q_BYPASS_EN
  logic bypass;
  logic consume;

  assign bypass  = empty && alloc;
  assign consume = bypass && dealloc;
  assign push_ok = alloc && (!full || dealloc) && !consume;
  assign pop_ok  = dealloc && !empty;
  assign valid   = !empty || alloc;
  assign head    = bypass ? in_req : mem[rd_ptr];
`else
  assign push_ok = alloc && (!full || dealloc);
  assign pop_ok  = dealloc && !empty;
  assign valid   = !empty;
  assign head    = mem[rd_ptr];
`endif

  assign addr_out      = head.addr;
  assign operation_out = head.operation;
  assign src_out       = head.src;
  assign dest_out      = head.dest;
  assign is_flush_out  = head.is_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Q_LENGTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= in_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // When full, push and pop hit the same slot; the push must win.
      if (pop_ok) begin
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push_ok) begin
        ent_vld[wr_ptr] <= 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < Q_LENGTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

  req_q_match #(
    .Q_LENGTH (Q_LENGTH),
    .ADDR_W   (ADDR_W),
    .CL_SIZE  (CL_SIZE)
  ) u_match (
    .entry_addr  (entry_addr),
    .entry_valid (ent_vld),
    .match_addr  (match_addr),
    .match_hit   (match_hit)
  );

endmodule

// File: tb/tb_req_q.sv
// Directed self-checking bench for req_q (default parameters, Q_LENGTH=8).
module tb_req_q;

  logic        clk;
  logic        rst;
  logic [31:0] addr_in;
  logic [2:0]  operation_in;
  logic        is_flush;
  logic [1:0]  src;
  logic [1:0]  dest;
  logic        alloc;
  logic        dealloc;
  logic [31:0] match_addr;
  logic        full;
  logic        almost_full;
  logic [3:0]  count;
  logic        match_hit;
  logic [31:0] addr_out;
  logic [2:0]  operation_out;
  logic [1:0]  src_out;
  logic [1:0]  dest_out;
  logic        is_flush_out;
  logic        valid;

  int n_total = 0;
  int n_pass  = 0;

  req_q dut (
    .clk           (clk),
    .rst           (rst),
    .addr_in       (addr_in),
    .operation_in  (operation_in),
    .is_flush      (is_flush),
    .src           (src),
    .dest          (dest),
    .alloc         (alloc),
    .dealloc       (dealloc),
    .match_addr    (match_addr),
    .full          (full),
    .almost_full   (almost_full),
    .count         (count),
    .match_hit     (match_hit),
    .addr_out      (addr_out),
    .operation_out (operation_out),
    .src_out       (src_out),
    .dest_out      (dest_out),
    .is_flush_out  (is_flush_out),
    .valid         (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [2:0] op,
                         input logic [1:0] s, input logic [1:0] d,
                         input logic f);
    addr_in      = a;
    operation_in = op;
    src          = s;
    dest         = d;
    is_flush     = f;
  endtask

  task automatic test_reset();
    n_total++;
    if ({valid, full, almost_full, match_hit} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {valid, full, almost_full, match_hit});
    else n_pass++;
    n_total++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
    n_total++;
    if ({addr_out, operation_out, src_out, dest_out, is_flush_out} !== 40'd0)
      $display("FAIL reset_data: got addr %h op %0d", addr_out, operation_out);
    else n_pass++;
  endtask

  task automatic test_single_push();
    set_req(32'h0000_1234, 3'd2, 2'd1, 2'd2, 1'b0);
    alloc = 1'b1;
    #1;
    n_total++;
    if (valid !== 1'b0) $display("FAIL single_latency: valid got %b want 0", valid);
    else n_pass++;
    step();
    alloc = 1'b0;
    n_total++;
    if (valid !== 1'b1 || count !== 4'd1)
      $display("FAIL single_state: valid %b count %0d want 1/1", valid, count);
    else n_pass++;
    n_total++;
    if (addr_out !== 32'h0000_1234 || operation_out !== 3'd2 || src_out !== 2'd1 ||
        dest_out !== 2'd2 || is_flush_out !== 1'b0)
      $display("FAIL single_data: got %h/%0d/%0d/%0d/%b want 00001234/2/1/2/0",
               addr_out, operation_out, src_out, dest_out, is_flush_out);
    else n_pass++;
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;
    n_total++;
    if (count !== 4'd0 || valid !== 1'b0)
      $display("FAIL single_pop: count %0d valid %b want 0/0", count, valid);
    else n_pass++;
  endtask

  task automatic test_pop_empty();
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;
    n_total++;
    if (count !== 4'd0 || valid !== 1'b0)
      $display("FAIL pop_empty: count %0d valid %b want 0/0", count, valid);
    else n_pass++;
    set_req(32'h0000_ABC0, 3'd1, 2'd3, 2'd0, 1'b1);
    alloc = 1'b1;
    step();
    alloc = 1'b0;
    n_total++;
    if (addr_out !== 32'h0000_ABC0 || is_flush_out !== 1'b1 || src_out !== 2'd3)
      $display("FAIL pop_empty_ptr: head %h flush %b src %0d want 0000abc0/1/3",
               addr_out, is_flush_out, src_out);
    else n_pass++;
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_req(32'h100 * (i + 1), 3'(i), 2'(i), 2'(i + 1), 1'b0);
      alloc = 1'b1;
      step();
      n_total++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6))
        $display("FAIL fill_%0d: count %0d af %b want %0d/%b",
                 i, count, almost_full, i + 1, (i + 1 >= 6));
      else n_pass++;
    end
    alloc = 1'b0;
    n_total++;
    if (full !== 1'b1 || addr_out !== 32'h100)
      $display("FAIL fill_full: full %b head %h want 1/00000100", full, addr_out);
    else n_pass++;
    $display("note: deliberate alloc while full (protocol error) to check drop");
    set_req(32'h0000_DEAD, 3'd7, 2'd3, 2'd3, 1'b1);
    alloc = 1'b1;
    step();
    alloc = 1'b0;
    n_total++;
    if (count !== 4'd8 || addr_out !== 32'h100 || full !== 1'b1)
      $display("FAIL overflow_drop: count %0d head %h want 8/00000100", count, addr_out);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    set_req(32'h900, 3'd4, 2'd2, 2'd3, 1'b0);
    alloc   = 1'b1;
    dealloc = 1'b1;
    step();
    alloc   = 1'b0;
    dealloc = 1'b0;
    n_total++;
    if (full !== 1'b1 || count !== 4'd8 || addr_out !== 32'h200)
      $display("FAIL full_pushpop: full %b count %0d head %h want 1/8/00000200",
               full, count, addr_out);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (addr_out !== 32'h100 * (i + 2))
        $display("FAIL full_drain_%0d: head %h want %h", i, addr_out, 32'h100 * (i + 2));
      else n_pass++;
      dealloc = 1'b1;
      step();
      dealloc = 1'b0;
    end
    n_total++;
    if (addr_out !== 32'h900 || operation_out !== 3'd4 || count !== 4'd1)
      $display("FAIL full_last: head %h op %0d count %0d want 00000900/4/1",
               addr_out, operation_out, count);
    else n_pass++;
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      set_req(32'h4000 + 32'(i * 16), 3'(i), 2'(i), 2'(i), i[0]);
      alloc = 1'b1;
      step();
      alloc = 1'b0;
      n_total++;
      if (count !== 4'd1 || addr_out !== 32'h4000 + 32'(i * 16) || is_flush_out !== i[0])
        $display("FAIL wrap_push_%0d: count %0d head %h want 1/%h",
                 i, count, addr_out, 32'h4000 + 32'(i * 16));
      else n_pass++;
      dealloc = 1'b1;
      step();
      dealloc = 1'b0;
      n_total++;
      if (count !== 4'd0)
        $display("FAIL wrap_pop_%0d: count %0d want 0", i, count);
      else n_pass++;
    end
  endtask

  task automatic test_match();
    set_req(32'h5000, 3'd0, 2'd0, 2'd0, 1'b0);
    match_addr = 32'h5004;
    alloc = 1'b1;
    #1;
    n_total++;
    if (match_hit !== 1'b0) $display("FAIL match_pushing: got %b want 0", match_hit);
    else n_pass++;
    step();
    alloc = 1'b0;
    n_total++;
    if (match_hit !== 1'b1) $display("FAIL match_pushed: got %b want 1", match_hit);
    else n_pass++;
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;

    set_req(32'h0000_1230, 3'd1, 2'd1, 2'd1, 1'b0);
    alloc = 1'b1;
    step();
    alloc = 1'b0;
    match_addr = 32'h0000_123C;
    #1;
    n_total++;
    if (match_hit !== 1'b1) $display("FAIL match_same_line: got %b want 1", match_hit);
    else n_pass++;
    match_addr = 32'h0000_1240;
    #1;
    n_total++;
    if (match_hit !== 1'b0) $display("FAIL match_next_line: got %b want 0", match_hit);
    else n_pass++;
    match_addr = 32'h0000_1238;
    dealloc = 1'b1;
    #1;
    n_total++;
    if (match_hit !== 1'b1) $display("FAIL match_popping: got %b want 1", match_hit);
    else n_pass++;
    step();
    dealloc = 1'b0;
    n_total++;
    if (match_hit !== 1'b0) $display("FAIL match_popped: got %b want 0", match_hit);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      set_req(32'h6000 + 32'(i * 32), 3'd3, 2'd2, 2'd1, 1'b1);
      alloc = 1'b1;
      step();
    end
    alloc = 1'b0;
    n_total++;
    if (count !== 4'd5) $display("FAIL mid_count: got %0d want 5", count);
    else n_pass++;
    match_addr = 32'h6000;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (count !== 4'd0 || valid !== 1'b0 || match_hit !== 1'b0 || full !== 1'b0)
      $display("FAIL mid_reset: count %0d valid %b hit %b full %b want 0/0/0/0",
               count, valid, match_hit, full);
    else n_pass++;
    n_total++;
    if (addr_out !== 32'd0 || is_flush_out !== 1'b0 || src_out !== 2'd0)
      $display("FAIL mid_reset_data: head %h flush %b want 0/0", addr_out, is_flush_out);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if (count !== 4'd0 || valid !== 1'b0)
      $display("FAIL mid_after: count %0d valid %b want 0/0", count, valid);
    else n_pass++;
  endtask

`ifdef REQ_Q_BYPASS_EN
  task automatic test_bypass();
    set_req(32'h7770, 3'd2, 2'd1, 2'd3, 1'b0);
    alloc = 1'b1;
    #1;
    n_total++;
    if (valid !== 1'b1 || addr_out !== 32'h7770 || count !== 4'd0)
      $display("FAIL bypass_same_cycle: valid %b head %h count %0d want 1/00007770/0",
               valid, addr_out, count);
    else n_pass++;
    dealloc = 1'b1;
    step();
    alloc   = 1'b0;
    dealloc = 1'b0;
    n_total++;
    if (count !== 4'd0 || valid !== 1'b0)
      $display("FAIL bypass_consume: count %0d valid %b want 0/0", count, valid);
    else n_pass++;
    alloc = 1'b1;
    step();
    alloc = 1'b0;
    n_total++;
    if (count !== 4'd1 || addr_out !== 32'h7770)
      $display("FAIL bypass_store: count %0d head %h want 1/00007770", count, addr_out);
    else n_pass++;
    dealloc = 1'b1;
    step();
    dealloc = 1'b0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    alloc      = 1'b0;
    dealloc    = 1'b0;
    match_addr = 32'd0;
    set_req(32'd0, 3'd0, 2'd0, 2'd0, 1'b0);
    #1;
    test_reset();
    step();
    step();
    rst = 1'b0;
    step();
    test_single_push();
    test_pop_empty();
    test_fill();
    test_full_push_pop();
    test_wrap();
    test_match();
    test_reset_mid();
`ifdef REQ_Q_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/req_q.md
Name: req_q

Overview:
- Parametrised in-order request queue between cache controllers.
- Replaces the fixed-width, single-mode instruction queue.
- Carries {src, dest, is_flush, operation, addr} per entry and adds occupancy count, almost-full warning, and a line-address match port so senders can detect same-line hazards before allocating.
- Sits between the L1 miss/flush logic and the lower-level cache/memory arbiter.

Parameters:
- Q_LENGTH, 8, number of entries; power of two, minimum 2.
- ADDR_W, 32, address width.
- OP_W, 3, operation code width.
- ID_W, 2, src/dest identifier width.
- CL_SIZE, 128, cache line size in bits; line offset bits = log2(CL_SIZE/8) = 4.
- AF_THRESH, Q_LENGTH-2, almost_full asserts when count >= AF_THRESH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_in  in  ADDR_W  request address.
- operation_in  in  OP_W  request opcode.
- is_flush  in  1  flush request flag.
- src  in  ID_W  source id.
- dest  in  ID_W  destination id.
- alloc  in  1  push request.
- dealloc  in  1  pop head entry.
- match_addr  in  ADDR_W  address probed for line hazard.
- full  out  1  no free entry.
- almost_full  out  1  count >= AF_THRESH.
- count  out  log2(Q_LENGTH)+1  occupied entries.
- match_hit  out  1  a valid entry holds the same line as match_addr.
- addr_out  out  ADDR_W  head address.
- operation_out  out  OP_W  head opcode.
- src_out  out  ID_W  head source.
- dest_out  out  ID_W  head destination.
- is_flush_out  out  1  head flush flag.
- valid  out  1  head entry valid (queue non-empty).

Behaviour:
- Reset (async, immediate):
  - Pointers, count and per-entry valid bits clear; storage clears to 0.
  - Outputs: valid=0, full=0, almost_full=0 (unless AF_THRESH=0), count=0, match_hit=0, all data outputs 0.
- Reset mid-operation discards all entries with no drain.
- Storage: circular buffer of Q_LENGTH entries.
  - wr_ptr and rd_ptr are log2(Q_LENGTH) bits and wrap naturally from Q_LENGTH-1 to 0.
  - count is the registered occupancy.
- Push:
  - Accepted when alloc && (!full || dealloc).
  - Entry is written at wr_ptr on the rising edge and becomes visible at the head no earlier than the next cycle (1-cycle latency).
- Pop:
  - Accepted when dealloc && valid; rd_ptr advances and the entry valid bit clears.
  - dealloc while empty is ignored; no pointer or count change.
- Simultaneous push and pop:
  - When non-empty, both occur and count is unchanged.
  - When full, the push is accepted into the slot freed by the pop; full stays 1.
  - When empty, only the push occurs.
- alloc while full without dealloc: request dropped, state unchanged.
  - The sender must gate on full; the bench flags this as a protocol error.
- Outputs:
  - full = (count == Q_LENGTH); valid = (count != 0); almost_full = (count >= AF_THRESH). All derive from registered state.
  - Data outputs show the entry at rd_ptr combinationally; values are don't-care while valid=0.
- Line match (combinational):
  - match_hit = OR over valid entries of (entry.addr[ADDR_W-1:OFF] == match_addr[ADDR_W-1:OFF]), with OFF = log2(CL_SIZE/8).
  - An entry being pushed this cycle is not yet included.
  - An entry being popped this cycle is still included.
- No FSM beyond the pointer/count state; all transitions occur on the clk rising edge.

Optional Feature:
- Macro: REQ_Q_BYPASS_EN.
- Defined:
  - When the queue is empty and alloc=1, the input fields drive the outputs combinationally and valid=1 in the same cycle.
  - If dealloc is also 1 that cycle, the request is consumed and never written; count stays 0.
  - If dealloc=0, the entry is written normally.
- Not defined: strict 1-cycle latency; valid depends only on registered count.

Decomposition:
- Shared package cache_pkg:
  - Operation code constants (read, write, evict, flush, upgrade).
  - src/dest id encodings (L1I, L1D, L2, MEM).
  - req_t packed struct {src, dest, is_flush, operation, addr}.
  - Offset-bit function derived from CL_SIZE.
- Sub-module req_q_match: per-entry line-address comparator array plus OR-reduction, parameterised on Q_LENGTH, ADDR_W and CL_SIZE.
- Pointers, count and storage stay in req_q.

Test Plan:
- Reset, then push 1 entry {addr=0x0000_1234, op=3'd2, src=1, dest=2, flush=0} -> next cycle valid=1, count=1, addr_out=0x0000_1234, op=2, src_out=1, dest_out=2.
- Push 8 entries with Q_LENGTH=8 -> count=8, full=1, almost_full=1 from count=6. A 9th alloc without dealloc -> dropped; head unchanged.
- Full queue, alloc+dealloc in the same cycle -> full stays 1, count=8. Head advances to entry 2; the new entry appears last after 7 more pops.
- Push and pop 20 entries alternately to force pointer wrap -> FIFO order preserved and count never exceeds 1.
- Queue holding addr 0x0000_1230: match_addr=0x0000_123C -> match_hit=1; match_addr=0x0000_1240 -> match_hit=0. After that entry pops -> match_hit=0.
- Assert rst mid-stream with count=5 -> outputs clear immediately without a clock edge. With REQ_Q_BYPASS_EN, alloc on an empty queue -> valid=1 in the same cycle.
